param_instruction_decoder: RTL and testbench
============================================

PARAM_INSTRUCTION_DECODER -- requirements
Module: param_instruction_decoder

Interface
REQ-001 SHALL have parameter INSTR_W, default 16: instruction width in bits.
REQ-002 SHALL have parameter OPC_W, default 4: opcode width, taken from instruct[INSTR_W-1 -: OPC_W].
REQ-003 SHALL have parameter REG_AW, default 3: register address width for rD, rA and rB.
REQ-004 SHALL have parameter XLEN, default 16: width of the extended immediate.
REQ-005 SHALL have parameter ILLEGAL_MASK, default all-zero, width 2**OPC_W: bit n set marks opcode n illegal.
REQ-006 SHALL derive IMM_W = INSTR_W-OPC_W-REG_AW-1 as a localparam, and elaboration SHALL fail unless INSTR_W >= OPC_W+3*REG_AW+1 and XLEN >= IMM_W.
REQ-007 clock  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 enable  in  1  acceptance enable; 0 blocks intake but not drain.
REQ-010 in_valid  in  1 / in_ready  out  1 / instruct  in  INSTR_W  form the input handshake.
REQ-011 out_valid  out  1 / out_ready  in  1  form the output handshake.
REQ-012 opcode  out  OPC_W / rDadrs, rAadrs, rBadrs  out  REG_AW / flag  out  1 / imm  out  IMM_W: decoded fields.
REQ-013 imm_ext  out  XLEN / illegal  out  1: extended immediate and illegal-opcode flag.

Function
REQ-014 Field map: opcode=[INSTR_W-1 -: OPC_W]; rD=next REG_AW bits down; flag=next bit; rA=next REG_AW bits; rB=next REG_AW bits; imm=[IMM_W-1:0]. rA/rB overlap imm by design.
REQ-015 imm_ext SHALL be imm sign-extended to XLEN when flag=1, otherwise zero-extended.
REQ-016 illegal SHALL be ILLEGAL_MASK[opcode] of the same packet.
REQ-017 Decode SHALL be combinational at intake; stored entries hold the fully decoded packet.
REQ-018 in_fire = in_valid & in_ready & enable; out_fire = out_valid & out_ready.
REQ-019 Storage SHALL be an output register plus one skid register, controlled by FSM states EMPTY, ONE and FULL.
REQ-020 in_ready SHALL be registered and SHALL equal (state != FULL); out_valid SHALL equal (state != EMPTY).
REQ-021 EMPTY: in_fire -> ONE, loading the output register.
REQ-022 ONE: in_fire & !out_fire -> FULL (loads skid); out_fire & !in_fire -> EMPTY; both -> ONE (loads output register with new packet).
REQ-023 FULL: out_fire -> ONE (output register takes skid); otherwise hold.
REQ-024 Latency SHALL be exactly 1 cycle from in_fire to out_valid when the block is EMPTY; sustained throughput SHALL be 1 packet/cycle with out_ready=1.
REQ-025 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 enable=0 SHALL block in_fire only; held packets SHALL still drain, and packet order SHALL always be preserved.

Reset
REQ-027 Reset SHALL force state=EMPTY, out_valid=0, in_ready=1, and all field outputs, imm_ext and illegal to 0.
REQ-028 Reset asserted mid-transfer SHALL discard both stored packets, with no partial output afterwards.

Configuration
REQ-029 With macro DECODER_STATS_EN defined, SHALL add outputs instr_count (32, counts out_fire, wraps) and illegal_count (16, counts out_fire with illegal=1, saturates at 16'hFFFF), both reset to 0.
REQ-030 Without DECODER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package decoder_pkg SHALL hold the FSM state enum (EMPTY/ONE/FULL) and the default parameter constants.
REQ-032 Field extraction, extension and illegal lookup SHALL live in combinational sub-module instr_field_decode, which is instantiated once at intake.

Verification
REQ-033 Defaults, instruct=16'hA5F3, one beat -> next cycle opcode=4'hA, rDadrs=2, flag=1, rAadrs=7, rBadrs=4, imm=8'hF3, imm_ext=16'hFFF3.
REQ-034 instruct=16'h3073 -> flag=0, imm=8'h73, imm_ext=16'h0073.
REQ-035 Hold out_ready=0 and push 3 packets -> 2 accepted, in_ready=0 in FULL; then out_ready=1 -> both delivered in order, in_ready returns to 1.
REQ-036 ILLEGAL_MASK bit 15 set, opcode 4'hF -> illegal=1; with DECODER_STATS_EN, illegal_count=1 and instr_count=1 after delivery.
REQ-037 Assert reset while FULL -> out_valid=0 and in_ready=1 immediately (asynchronously); no stale packet appears after release.
REQ-038 enable=0 with in_valid=1 for 5 cycles -> no acceptance while the stored packet still drains; enable=1 -> accepted next edge.

Source files
------------

// File: rtl/param_instruction_decoder_pkg.sv
// Shared types and default sizing for the instruction decoder slice.
package decoder_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_OPC_W   = 4;
    localparam int DEF_REG_AW  = 3;
    localparam int DEF_XLEN    = 16;
endpackage

// File: rtl/param_instruction_decoder_if.sv
// Handshake and decoded-field bundle between the decoder and its producer/consumer.
interface param_instruction_decoder_if #(
    parameter int INSTR_W = decoder_pkg::DEF_INSTR_W,
    parameter int OPC_W   = decoder_pkg::DEF_OPC_W,
    parameter int REG_AW  = decoder_pkg::DEF_REG_AW,
    parameter int XLEN    = decoder_pkg::DEF_XLEN
);
    import decoder_pkg::*;
    localparam int IMM_W = INSTR_W - OPC_W - REG_AW - 1;

    // A beat transfers on a rising edge where valid and ready are both high
    // (intake additionally needs enable); valid never depends on ready.
    logic               enable;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruct;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   opcode;
    logic [REG_AW-1:0]  rDadrs;
    logic [REG_AW-1:0]  rAadrs;
    logic [REG_AW-1:0]  rBadrs;
    logic               flag;
    logic [IMM_W-1:0]   imm;
    logic [XLEN-1:0]    imm_ext;
    logic               illegal;
    state_t             fsm_state;

    modport master (
        output enable, in_valid, instruct, out_ready,
        input  in_ready, out_valid, opcode, rDadrs, rAadrs, rBadrs,
               flag, imm, imm_ext, illegal, fsm_state
    );

    modport slave (
        input  enable, in_valid, instruct, out_ready,
        output in_ready, out_valid, opcode, rDadrs, rAadrs, rBadrs,
               flag, imm, imm_ext, illegal, fsm_state
    );
endinterface

// File: rtl/param_instruction_decoder_decode.sv
// Combinational field extraction, immediate extension and illegal-opcode lookup.
module instr_field_decode #(
    parameter int                      INSTR_W      = decoder_pkg::DEF_INSTR_W,
    parameter int                      OPC_W        = decoder_pkg::DEF_OPC_W,
    parameter int                      REG_AW       = decoder_pkg::DEF_REG_AW,
    parameter int                      XLEN         = decoder_pkg::DEF_XLEN,
    parameter logic [(2**OPC_W)-1:0]   ILLEGAL_MASK = '0,
    localparam int                     IMM_W        = INSTR_W - OPC_W - REG_AW - 1
) (
    input  logic [INSTR_W-1:0] instruct,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_AW-1:0]  rd,
    output logic               flag,
    output logic [REG_AW-1:0]  ra,
    output logic [REG_AW-1:0]  rb,
    output logic [IMM_W-1:0]   imm,
    output logic [XLEN-1:0]    imm_ext,
    output logic               illegal
);
    // rA and rB deliberately alias the upper bits of the immediate.
    assign opcode  = instruct[INSTR_W-1 -: OPC_W];
    assign rd      = instruct[INSTR_W-OPC_W-1 -: REG_AW];
    assign flag    = instruct[IMM_W];
    assign ra      = instruct[IMM_W-1 -: REG_AW];
    assign rb      = instruct[IMM_W-REG_AW-1 -: REG_AW];
    assign imm     = instruct[IMM_W-1:0];
    assign illegal = ILLEGAL_MASK[opcode];

    for (genvar i = 0; i < XLEN; i++) begin : g_ext
        if (i < IMM_W) begin : g_low
            assign imm_ext[i] = imm[i];
        end else begin : g_high
            assign imm_ext[i] = flag & imm[IMM_W-1];
        end
    end
endmodule

// File: rtl/param_instruction_decoder.sv
// Instruction decoder with a two-entry (output + skid) elastic buffer.
// Optional DECODER_STATS_EN adds delivered/illegal packet counters.
module param_instruction_decoder
    import decoder_pkg::*;
#(
    parameter int                    INSTR_W      = DEF_INSTR_W,
    parameter int                    OPC_W        = DEF_OPC_W,
    parameter int                    REG_AW       = DEF_REG_AW,
    parameter int                    XLEN         = DEF_XLEN,
    parameter logic [(2**OPC_W)-1:0] ILLEGAL_MASK = '0
) (
    input  logic                      clock,
    input  logic                      reset,
`ifdef DECODER_STATS_EN
    output logic [31:0]               instr_count,
    output logic [15:0]               illegal_count,
`endif
    param_instruction_decoder_if.slave bus
);
    localparam int IMM_W = INSTR_W - OPC_W - REG_AW - 1;
    localparam int PKT_W = OPC_W + 3 * REG_AW + 1 + IMM_W + XLEN + 1;

    if ((INSTR_W < OPC_W + 3 * REG_AW + 1) || (XLEN < IMM_W)) begin : g_bad_cfg
        $error("param_instruction_decoder: INSTR_W/XLEN too small for the field map");
    end

    logic [OPC_W-1:0]  d_opcode;
    logic [REG_AW-1:0] d_rd, d_ra, d_rb;
    logic              d_flag, d_illegal;
    logic [IMM_W-1:0]  d_imm;
    logic [XLEN-1:0]   d_ext;

    instr_field_decode #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_AW(REG_AW),
        .XLEN(XLEN), .ILLEGAL_MASK(ILLEGAL_MASK)
    ) u_decode (
        .instruct(bus.instruct), .opcode(d_opcode), .rd(d_rd), .flag(d_flag),
        .ra(d_ra), .rb(d_rb), .imm(d_imm), .imm_ext(d_ext), .illegal(d_illegal)
    );

    logic [PKT_W-1:0] dec_pkt, out_q, skid_q;
    state_t           state;
    logic             in_ready_q, out_valid_q, in_fire, out_fire;

    assign dec_pkt  = {d_opcode, d_rd, d_flag, d_ra, d_rb, d_imm, d_ext, d_illegal};
    assign in_fire  = bus.in_valid & in_ready_q & bus.enable;
    assign out_fire = out_valid_q & bus.out_ready;

    // out_q always holds the oldest packet; skid_q only the younger one in FULL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_q       <= dec_pkt;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q     <= dec_pkt;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (out_fire && !in_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end else if (in_fire && out_fire) begin
                        out_q <= dec_pkt;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fsm_state = state;
    assign {bus.opcode, bus.rDadrs, bus.flag, bus.rAadrs, bus.rBadrs,
            bus.imm, bus.imm_ext, bus.illegal} = out_q;

`ifdef DECODER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_count   <= '0;
            illegal_count <= '0;
        end else if (out_fire) begin
            instr_count <= instr_count + 32'd1;
            if (out_q[0] && (illegal_count != 16'hFFFF)) begin
                illegal_count <= illegal_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_param_instruction_decoder.sv
// Randomized scoreboard bench for param_instruction_decoder (default widths).
module tb_param_instruction_decoder;
    import decoder_pkg::*;

    localparam logic [15:0] TB_MASK = 16'h8104;
    localparam int          PKT_W   = 4 + 3 + 3 + 3 + 1 + 8 + 16 + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    param_instruction_decoder_if bus ();
`ifdef DECODER_STATS_EN
    logic [31:0] instr_count;
    logic [15:0] illegal_count;
`endif

    param_instruction_decoder #(.ILLEGAL_MASK(TB_MASK)) dut (
        .clock(clock),
        .reset(reset),
`ifdef DECODER_STATS_EN
        .instr_count(instr_count),
        .illegal_count(illegal_count),
`endif
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_accept = 0;
    int exp_instr_cnt = 0;
    int exp_illegal_cnt = 0;
    logic [PKT_W-1:0] exp_q[$];
    logic [PKT_W-1:0] got_pkt;

    assign got_pkt = {bus.opcode, bus.rDadrs, bus.rAadrs, bus.rBadrs, bus.flag,
                      bus.imm, bus.imm_ext, bus.illegal};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode straight from the field map, using integer arithmetic.
    function automatic logic [PKT_W-1:0] ref_model(input logic [15:0] ins);
        int u, opc, rd, fl, ra, rb, im, ext, ill;
        u   = int'(ins);
        opc = u / 4096;
        rd  = (u / 512) % 8;
        fl  = (u / 256) % 2;
        ra  = (u / 32) % 8;
        rb  = (u / 4) % 8;
        im  = u % 256;
        ext = (fl == 1 && im >= 128) ? im + 65280 : im;
        ill = int'((TB_MASK >> opc) & 16'd1);
        return {opc[3:0], rd[2:0], ra[2:0], rb[2:0], fl[0], im[7:0], ext[15:0], ill[0]};
    endfunction

    // Monitor: occupancy, head-of-queue contents (held stable while stalled), pops and pushes.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("out_valid_vs_model", 64'(bus.out_valid), 64'(exp_q.size() != 0));
                check("in_ready_vs_model", 64'(bus.in_ready), 64'(exp_q.size() < 2));
                if (bus.out_valid && exp_q.size() > 0) begin
                    check("packet", 64'(got_pkt), 64'(exp_q[0]));
                    if (bus.out_ready) begin
                        exp_instr_cnt++;
                        if (exp_q[0][0] && exp_illegal_cnt < 65535) exp_illegal_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
                if (bus.in_valid && bus.in_ready && bus.enable) begin
                    exp_q.push_back(ref_model(bus.instruct));
                    n_accept++;
                end
            end
        end
    end

    task automatic send(input logic [15:0] ins);
        @(posedge clock); #1;
        bus.in_valid = 1'b1;
        bus.instruct = ins;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_instr_cnt = 0;
        exp_illegal_cnt = 0;
    endtask

    initial begin
        int acc0;
        bus.enable    = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instruct  = '0;
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_fields", 64'(got_pkt), 64'd0);
        check("rst_state", 64'(bus.fsm_state), 64'(EMPTY));
        reset = 1'b0;

        send(16'hA5F3);
        @(negedge clock);
        check("a5f3_opcode", 64'(bus.opcode), 64'hA);
        check("a5f3_rd", 64'(bus.rDadrs), 64'd2);
        check("a5f3_flag", 64'(bus.flag), 64'd1);
        check("a5f3_ra", 64'(bus.rAadrs), 64'd7);
        check("a5f3_rb", 64'(bus.rBadrs), 64'd4);
        check("a5f3_imm", 64'(bus.imm), 64'hF3);
        check("a5f3_imm_ext", 64'(bus.imm_ext), 64'hFFF3);

        send(16'h3073);
        @(negedge clock);
        check("3073_flag", 64'(bus.flag), 64'd0);
        check("3073_imm", 64'(bus.imm), 64'h73);
        check("3073_imm_ext", 64'(bus.imm_ext), 64'h0073);

        // Stall the output and offer three packets: only two fit.
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        acc0 = n_accept;
        bus.in_valid = 1'b1;
        bus.instruct = 16'h1234;
        @(posedge clock); #1;
        bus.instruct = 16'hC9A7;
        @(posedge clock); #1;
        bus.instruct = 16'h7E81;
        repeat (2) @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check("full_accepted", 64'(n_accept - acc0), 64'd2);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_state", 64'(bus.fsm_state), 64'(FULL));
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("drain_in_ready", 64'(bus.in_ready), 64'd1);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        // Fill to FULL, then reset in the middle of a cycle.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instruct  = 16'h5555;
        @(posedge clock); #1;
        bus.instruct  = 16'h9AAA;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        check("pre_reset_state", 64'(bus.fsm_state), 64'(FULL));
        @(negedge clock); #2;
        do_reset();
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("async_rst_fields", 64'(got_pkt), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        send(16'hF000);
        @(negedge clock);
        check("illegal_flag", 64'(bus.illegal), 64'd1);
        @(posedge clock); #1;
`ifdef DECODER_STATS_EN
        check("stats_instr_count", 64'(instr_count), 64'd1);
        check("stats_illegal_count", 64'(illegal_count), 64'd1);
`endif

        // enable=0 blocks intake while the held packet drains.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instruct  = 16'h2468;
        @(posedge clock); #1;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b1;
        bus.instruct  = 16'hB3C5;
        acc0 = n_accept;
        repeat (5) @(posedge clock);
        #1;
        check("enable_blocked", 64'(n_accept - acc0), 64'd0);
        check("enable_drained", 64'(bus.out_valid), 64'd0);
        bus.enable = 1'b1;
        @(posedge clock); #1;
        check("enable_accept", 64'(n_accept - acc0), 64'd1);
        bus.in_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.enable    = ($urandom_range(0, 4) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.instruct  = 16'($urandom_range(0, 65535));
        end
        @(posedge clock); #1;
        bus.in_valid  = 1'b0;
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_out_valid", 64'(bus.out_valid), 64'd0);
`ifdef DECODER_STATS_EN
        check("final_instr_count", 64'(instr_count), 64'(exp_instr_cnt));
        check("final_illegal_count", 64'(illegal_count), 64'(exp_illegal_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
